// File: rtl/noc_tx_pkg.sv
// Shared definitions for the NoC link transmitter: flit type codes,
// framing FSM state encoding and a constant clog2 helper.
package noc_tx_pkg;

  // Flit type codes carried in the top two bits of every flit
  localparam logic [1:0] FLIT_BODY   = 2'b00;
  localparam logic [1:0] FLIT_HEAD   = 2'b01;
  localparam logic [1:0] FLIT_TAIL   = 2'b10;
  localparam logic [1:0] FLIT_SINGLE = 2'b11;

  // Packet framing tracker states
  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } tx_state_e;

  // Ceiling log2, usable in constant expressions such as port widths
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for credit-based flow control against the downstream
// buffer. Starts full at CREDITS, a consume takes one credit, a return
// gives one back, and a return while already full is flagged as a sticky
// overflow instead of growing the count.
module noc_credit_counter
  import noc_tx_pkg::*;
#(
  parameter int CREDITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  consume,
  input  logic                  credit_ret,
  output logic [clog2(CREDITS):0] count,
  output logic                  ovf
);

  localparam int CW = clog2(CREDITS) + 1;
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  localparam logic [CW-1:0] ONE  = CW'(1);

  // Count update: simultaneous consume and return cancel each other out
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= FULL;
      ovf   <= 1'b0;
    end else begin
      if (consume && !credit_ret) begin
        if (count != '0) begin
          count <= count - ONE;
        end
      end else if (credit_ret && !consume) begin
        if (count == FULL) begin
          ovf <= 1'b1;
        end else begin
          count <= count + ONE;
        end
      end
    end
  end

endmodule

// File: rtl/noc_link_tx.sv
// NoC link transmitter: drains a router port FIFO (1-cycle registered
// read) onto a point-to-point link under credit flow control, tracks
// head/body/tail framing and pulses pkt_sent per completed packet.
// Note: rst_n is an active-high asynchronous reset despite its name.
// Optional: define NOC_LINK_TX_PARITY_EN to drive even parity on
// link_parity; otherwise link_parity is tied to 0.
module noc_link_tx
  import noc_tx_pkg::*;
#(
  parameter int NUM_BITS = 8,
  parameter int CREDITS  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [NUM_BITS-1:0]     fifo_data,
  input  logic                    link_hold,
  input  logic                    credit_in,
  output logic                    link_valid,
  output logic [NUM_BITS-1:0]     link_data,
  output logic                    link_parity,
  output logic [clog2(CREDITS):0] credit_cnt,
  output logic                    pkt_sent,
  output logic                    framing_err,
  output logic                    credit_ovf
);

  tx_state_e  state;
  tx_state_e  state_next;
  logic       pkt_sent_next;
  logic       ferr_set;
  logic [1:0] flit_type;

  // A pop needs data, no hold, a free downstream slot, and no reset in progress
  assign fifo_rd_en = !fifo_empty && !link_hold && (credit_cnt != '0) && !rst_n;

  noc_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk        (clk),
    .rst_n      (rst_n),
    .consume    (fifo_rd_en),
    .credit_ret (credit_in),
    .count      (credit_cnt),
    .ovf        (credit_ovf)
  );

  // The FIFO read data arrives one cycle after the pop, so valid follows the pop by one cycle
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      link_valid <= 1'b0;
    end else begin
      link_valid <= fifo_rd_en;
    end
  end

  assign link_data = link_valid ? fifo_data : '0;
  assign flit_type = link_data[NUM_BITS-1 -: 2];

  // Framing state, registered packet-done pulse and sticky framing error
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state       <= IDLE;
      pkt_sent    <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      state    <= state_next;
      pkt_sent <= pkt_sent_next;
      if (ferr_set) begin
        framing_err <= 1'b1;
      end
    end
  end

  // Framing decisions are only made on cycles that actually carry a flit
  always_comb begin
    state_next    = state;
    pkt_sent_next = 1'b0;
    ferr_set      = 1'b0;
    if (link_valid) begin
      case (state)
        IDLE: begin
          case (flit_type)
            FLIT_HEAD:   state_next = IN_PKT;
            FLIT_SINGLE: pkt_sent_next = 1'b1;
            default:     ferr_set = 1'b1;
          endcase
        end
        IN_PKT: begin
          case (flit_type)
            FLIT_BODY: state_next = IN_PKT;
            FLIT_TAIL: begin
              state_next    = IDLE;
              pkt_sent_next = 1'b1;
            end
            FLIT_HEAD: begin
              state_next = IN_PKT;
              ferr_set   = 1'b1;
            end
            default: begin
              state_next    = IDLE;
              ferr_set      = 1'b1;
              pkt_sent_next = 1'b1;
            end
          endcase
        end
        default: state_next = IDLE;
      endcase
    end
  end

`ifdef NOC_LINK_TX_PARITY_EN
  assign link_parity = link_valid & (^link_data);
`else
  assign link_parity = 1'b0;
`endif

endmodule

// File: doc/noc_link_tx.md
Name: noc_link_tx

Overview:
- Drain side of a router input/output buffer: pops flits from a buffer FIFO and transmits them onto a point-to-point NoC link.
- Uses credit-based flow control against the downstream buffer.
- Tracks packet framing (head/body/tail) and pulses per completed packet.
- Sits between a router port FIFO (1-cycle registered read, empty flag) and the physical link.

Parameters:
- NUM_BITS, 8, flit width; top 2 bits are flit type.
- CREDITS, 8, downstream buffer depth and reset credit value; power of 2, >=2.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-high
- fifo_empty  in  1  buffer FIFO empty flag
- fifo_rd_en  out  1  FIFO pop request (combinational)
- fifo_data  in  NUM_BITS  FIFO registered read data, valid the cycle after a pop
- link_hold  in  1  stalls issue of new pops
- credit_in  in  1  one-cycle pulse, downstream freed one slot
- link_valid  out  1  flit on link this cycle
- link_data  out  NUM_BITS  flit; fifo_data when link_valid=1, else 0
- link_parity  out  1  even parity of link_data (see Optional Feature)
- credit_cnt  out  clog2(CREDITS)+1  available credits
- pkt_sent  out  1  pulse, tail or single flit transmitted
- framing_err  out  1  sticky, framing violation seen
- credit_ovf  out  1  sticky, credit returned while already at CREDITS

Behaviour:
- Reset: link_valid=0, credit_cnt=CREDITS, FSM=IDLE, pkt_sent=0, framing_err=0, credit_ovf=0.
- fifo_rd_en = !fifo_empty && !link_hold && (credit_cnt != 0) && !rst_n.
- A pop reserves a credit in the same cycle.
- Latency: link_valid is a register set to the previous cycle's fifo_rd_en, so a flit appears exactly 1 cycle after its pop. Back-to-back pops give back-to-back flits, 1 flit/cycle max.
- Credit counter, updated on posedge:
  - pop only: -1.
  - credit_in only: +1.
  - both: unchanged.
  - credit_in at CREDITS without pop: count holds, credit_ovf sets.
  - Count never below 0 (pop gated) and never above CREDITS.
- Flit type = link_data[NUM_BITS-1:NUM_BITS-2]: 01 head, 00 body, 10 tail, 11 single.
- FSM evaluated only in cycles with link_valid=1:
  - IDLE: head -> IN_PKT; single -> IDLE with pkt_sent=1; body/tail -> IDLE with framing_err set.
  - IN_PKT: body -> IN_PKT; tail -> IDLE with pkt_sent=1; head -> IN_PKT with framing_err set (new packet restarts); single -> IDLE with framing_err set and pkt_sent=1.
- pkt_sent is registered, asserted the cycle after the qualifying flit, width 1 cycle.
- link_hold asserted mid-packet stops further pops immediately. A flit already popped is still transmitted next cycle. FSM state is preserved.
- Reset mid-operation: any in-flight flit is discarded (link_valid forced 0), credits restored to CREDITS, sticky flags cleared. The FIFO shares rst_n.
- framing_err and credit_ovf clear only on reset.

Optional Feature:
- Macro NOC_LINK_TX_PARITY_EN.
- Defined: link_parity = XOR of link_data when link_valid=1, else 0.
- Undefined: link_parity tied 0, no parity logic.

Decomposition:
- Package noc_tx_pkg holds:
  - flit type constants FLIT_BODY=2'b00, FLIT_HEAD=2'b01, FLIT_TAIL=2'b10, FLIT_SINGLE=2'b11;
  - FSM state encoding IDLE/IN_PKT;
  - shared clog2 function.
- One sub-module, noc_credit_counter: parameter CREDITS; inputs consume/return; outputs count/ovf.

Test Plan:
- Reset then FIFO holds 3 flits (head 0x41, body 0x05, tail 0x86), credits=8, no hold -> rd_en cycles 1-3, link_valid cycles 2-4 with same data, credit_cnt ends 5, one pkt_sent pulse cycle 5.
- CREDITS=8, FIFO holds 10 single flits, no credit_in -> exactly 8 flits sent, rd_en low with credit_cnt=0. One credit_in pulse -> exactly 1 more flit sent.
- Simultaneous pop and credit_in at credit_cnt=4 -> credit_cnt stays 4. credit_in at credit_cnt=8 with no pop -> stays 8, credit_ovf=1.
- Body flit 0x03 in IDLE -> framing_err=1, FSM IDLE. Head 0x41 then head 0x42 -> framing_err=1, FSM IN_PKT, no pkt_sent.
- link_hold raised the cycle after the pop of body 0x05 -> that flit still transmitted; no further rd_en while hold=1. Release -> tail sent, pkt_sent pulse.
- rst_n pulsed the cycle after a pop -> link_valid=0 next cycle, credit_cnt=8, flags 0. With NOC_LINK_TX_PARITY_EN defined, flit 0x07 -> link_parity=1.
